// File: rtl/button_conditioner.sv
// ============================================================================
// Module  : button_conditioner
// Brief   : Three-channel push-button synchronizer, debouncer and press-pulse
//           generator. Define BUTTON_AUTO_REPEAT_EN to add auto-repeat pulses
//           on the left and right channels.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  input  logic function_raw,
  output logic left_btn,
  output logic right_btn,
  output logic function_btn,
  output logic left_pulse,
  output logic right_pulse,
  output logic function_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] C_DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY    < 2 || REPEAT_DELAY    > 65535 ||
      REPEAT_PERIOD   < 2 || REPEAT_PERIOD   > 65535) begin : g_bad_param
    $error("button_conditioner: parameter out of range 2..65535");
  end

  logic [2:0] w_raw;
  logic [2:0] r_btn;
  logic [2:0] r_pulse;

  assign w_raw = {function_raw, right_raw, left_raw};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [1:0]  r_sync;
    logic        w_s;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_level_nxt;
    logic        w_press;
    logic        w_rep_fire;

    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= 2'b00;
      end else begin
        r_sync <= {r_sync[0], w_raw[i]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= IDLE;
        r_cnt      <= 16'd0;
        r_btn[i]   <= 1'b0;
        r_pulse[i] <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_btn[i]   <= w_level_nxt;
        r_pulse[i] <= w_press | w_rep_fire;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_btn[i];
      w_press     = 1'b0;
      case (r_state)
        IDLE: begin
          w_level_nxt = 1'b0;
          if (w_s) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = 16'd0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 16'd0;
          end else if (r_cnt == C_DEB_LAST) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = 16'd0;
            w_level_nxt = 1'b1;
            w_press     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        HELD: begin
          w_level_nxt = 1'b1;
          if (!w_s) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = 16'd0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to HELD is a continuation of the same press.
          if (w_s) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = 16'd0;
          end else if (r_cnt == C_DEB_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 16'd0;
            w_level_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 16'd0;
          w_level_nxt = 1'b0;
        end
      endcase
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    if (i != 2) begin : g_rep
      localparam logic [15:0] C_REP_FIRST = 16'(REPEAT_DELAY - 1);
      localparam logic [15:0] C_REP_NEXT  = 16'(REPEAT_PERIOD - 1);

      logic [15:0] r_rep_cnt;
      logic        r_rep_phase;

      // Counter restarts at every emitted pulse; phase selects delay vs period.
      assign w_rep_fire = (r_state == HELD) && w_s &&
                          (r_rep_cnt == (r_rep_phase ? C_REP_NEXT : C_REP_FIRST));

      always_ff @(posedge clk) begin
        if (rst || r_state == IDLE || w_press) begin
          r_rep_cnt   <= 16'd0;
          r_rep_phase <= 1'b0;
        end else if (r_state == HELD && w_s) begin
          if (w_rep_fire) begin
            r_rep_cnt   <= 16'd0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 16'd1;
          end
        end
      end
    end else begin : g_norep
      assign w_rep_fire = 1'b0;
    end
`else
    assign w_rep_fire = 1'b0;
`endif
  end

  assign left_btn       = r_btn[0];
  assign right_btn      = r_btn[1];
  assign function_btn   = r_btn[2];
  assign left_pulse     = r_pulse[0];
  assign right_pulse    = r_pulse[1];
  assign function_pulse = r_pulse[2];

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module  : tb_button_conditioner
// Brief   : Directed self-checking bench for button_conditioner (4/10/3 build).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic function_raw = 1'b0;
  logic left_btn, right_btn, function_btn;
  logic left_pulse, right_pulse, function_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .left_raw      (left_raw),
    .right_raw     (right_raw),
    .function_raw  (function_raw),
    .left_btn      (left_btn),
    .right_btn     (right_btn),
    .function_btn  (function_btn),
    .left_pulse    (left_pulse),
    .right_pulse   (right_pulse),
    .function_pulse(function_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    left_raw     = 1'b0;
    right_raw    = 1'b0;
    function_raw = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] all_outs();
    return {left_btn, right_btn, function_btn, left_pulse, right_pulse, function_pulse};
  endfunction

  // Edges at which left_pulse is expected while left is held for 30 cycles.
  function automatic logic rep_expected(input int e);
`ifdef BUTTON_AUTO_REPEAT_EN
    return (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28 || e == 31);
`else
    return (e == 6);
`endif
  endfunction

  initial begin
    int pulses;

    do_reset();
    check("reset_outs", 32'(all_outs()), 32'd0);

    // Single left press, then release.
    left_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("l_btn_e%0d", e),   32'(left_btn),   32'(e >= 6));
      check($sformatf("l_pulse_e%0d", e), 32'(left_pulse), 32'(e == 6));
      check($sformatf("l_others_e%0d", e),
            32'({right_btn, function_btn, right_pulse, function_pulse}), 32'd0);
    end
    left_raw = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("l_rel_btn_e%0d", e),   32'(left_btn),   32'(e < 6));
      check($sformatf("l_rel_pulse_e%0d", e), 32'(left_pulse), 32'd0);
    end

    // Bouncing right input never settles long enough.
    do_reset();
    for (int e = 0; e < 20; e++) begin
      right_raw = (e < 12) && (e % 2 == 0);
      tick();
      check($sformatf("r_bounce_e%0d", e), 32'({right_btn, right_pulse}), 32'd0);
    end

    // Function held 40 cycles: one pulse, level falls 6 edges after release.
    do_reset();
    function_raw = 1'b1;
    pulses = 0;
    for (int e = 0; e < 50; e++) begin
      if (e == 40) function_raw = 1'b0;
      tick();
      pulses += int'(function_pulse);
      if (e == 45) check("f_btn_e45", 32'(function_btn), 32'd1);
      if (e == 46) check("f_btn_e46", 32'(function_btn), 32'd0);
    end
    check("f_pulse_count", 32'(pulses), 32'd1);

    // Left held 30 cycles: press pulse plus any auto-repeat pulses.
    do_reset();
    left_raw = 1'b1;
    for (int e = 0; e < 41; e++) begin
      if (e == 30) left_raw = 1'b0;
      tick();
      check($sformatf("l_rep_e%0d", e), 32'(left_pulse), 32'(rep_expected(e)));
    end

    // Left and right together.
    do_reset();
    left_raw  = 1'b1;
    right_raw = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      check($sformatf("lr_e%0d", e),
            32'({left_btn, right_btn, left_pulse, right_pulse}),
            (e == 6) ? 32'hF : 32'h0);
    end

    // Reset mid-PRESS_WAIT on the function channel.
    do_reset();
    function_raw = 1'b1;
    pulses = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      pulses += int'(function_pulse);
    end
    check("rst_pre_pulses", 32'(pulses), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_mid_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0;
    for (int e = 5; e < 16; e++) begin
      tick();
      pulses += int'(function_pulse);
      if (e == 10) check("rst_f_btn_e10", 32'({function_btn, function_pulse}), 32'd0);
      if (e == 11) check("rst_f_btn_e11", 32'({function_btn, function_pulse}), 32'd3);
    end
    check("rst_pulse_count", 32'(pulses), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
